// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures retired-instruction commits into a DEPTH-entry circular buffer
//   and presents the oldest entry on a valid/ready output port.
//   Capture starts from ARMED on the first candidate commit, optionally
//   gated by a pc trigger. When the buffer is full, the module either stops
//   (WRAP_MODE=0) or overwrites the oldest entry (WRAP_MODE=1). Lost commits
//   are counted and also flagged with a sticky overflow bit.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   update_i              one commit retired this cycle
//   pc_i, instr_i         committed pc / instruction word
//   reg_addr_i, reg_data_i destination register (0 = none) and write data
//   filter_en_i           keep only commits that write a register
//   trig_en_i, trig_pc_i  hold capture in ARMED until pc_i == trig_pc_i
//   clear_i               synchronous flush / re-arm / flag clear
//   valid_o, ready_i      output handshake; pop on valid_o & ready_i
//   out_*_o               head (oldest) entry, read combinationally
//   count_o               number of stored entries
//   overflow_o            sticky: a commit was dropped or overwritten
//   drop_cnt_o            saturating count of lost commits
//   state_o               ARMED=0, CAPTURE=1, STOPPED=2
module commit_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic                       filter_en_i,
  input  logic                       trig_en_i,
  input  logic [XLEN-1:0]            trig_pc_i,
  input  logic                       clear_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [XLEN-1:0]            out_instr_o,
  output logic [4:0]                 out_reg_addr_o,
  output logic [XLEN-1:0]            out_reg_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;

  // Entry storage; contents are don't-care after reset.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [4:0]      ra_mem    [DEPTH];
  logic [XLEN-1:0] data_mem  [DEPTH];

  logic candidate;
  logic full;
  logic pop;
  logic wr_en;
  logic overwrite;
  logic drop;

  assign candidate = update_i & (~filter_en_i | (reg_addr_i != 5'd0));
  assign full      = (count_q == CW'(DEPTH));
  assign valid_o   = (count_q != '0);
  assign pop       = valid_o & ready_i;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    overwrite = 1'b0;
    drop      = 1'b0;

    if (clear_i) begin
      state_d = ST_ARMED;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          // Buffer is always empty here, so the triggering push cannot overflow.
          if (candidate && (!trig_en_i || (pc_i == trig_pc_i))) begin
            wr_en   = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (candidate) begin
            if (!full || pop) begin
              wr_en = 1'b1;
            end else if (WRAP_MODE != 0) begin
              wr_en     = 1'b1;
              overwrite = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
        ST_STOPPED: begin
          drop = candidate;
        end
        default: state_d = ST_ARMED;
      endcase

      if (wr_en) wptr_d = wptr_q + AW'(1);
      // An overwrite consumes the oldest slot, so the read side moves too.
      if (pop || overwrite) rptr_d = rptr_q + AW'(1);

      if (wr_en && !pop && !overwrite) count_d = count_q + CW'(1);
      else if (pop && !wr_en)          count_d = count_q - CW'(1);

      if (overwrite || drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end

      if ((WRAP_MODE == 0) && (state_q == ST_CAPTURE) && (count_d == CW'(DEPTH)))
        state_d = ST_STOPPED;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ARMED;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem[wptr_q]    <= pc_i;
      instr_mem[wptr_q] <= instr_i;
      ra_mem[wptr_q]    <= reg_addr_i;
      data_mem[wptr_q]  <= reg_data_i;
    end
  end

  assign out_pc_o       = pc_mem[rptr_q];
  assign out_instr_o    = instr_mem[rptr_q];
  assign out_reg_addr_o = ra_mem[rptr_q];
  assign out_reg_data_o = data_mem[rptr_q];
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign drop_cnt_o     = drop_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Testbench for commit_trace_buffer: two DEPTH=4 instances (stop-on-full and
// overwrite-oldest) share one stimulus stream. A vector table covers
// ordering, trigger, filter and stop-on-full; hand-written sequences cover
// wrap-around, full push+pop and asynchronous reset.
module tb_commit_trace_buffer;

  localparam logic [31:0] TRIG_PC = 32'h8000_0010;
  localparam logic [31:0] INSTR_X = 32'hA5A5_0000;
  localparam logic [31:0] DATA_O  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        update;
  logic [31:0] pc, instr, reg_data, trig_pc;
  logic [4:0]  reg_addr;
  logic        filter_en, trig_en, clear, ready;

  logic        v0, v1;
  logic [31:0] opc0, opc1, oin0, oin1, od0, od1;
  logic [4:0]  ora0, ora1;
  logic [2:0]  cnt0, cnt1;
  logic        ovf0, ovf1;
  logic [15:0] drp0, drp1;
  logic [1:0]  st0, st1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP_MODE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .update_i(update), .pc_i(pc), .instr_i(instr),
    .reg_addr_i(reg_addr), .reg_data_i(reg_data), .filter_en_i(filter_en),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .clear_i(clear),
    .valid_o(v0), .ready_i(ready), .out_pc_o(opc0), .out_instr_o(oin0),
    .out_reg_addr_o(ora0), .out_reg_data_o(od0), .count_o(cnt0),
    .overflow_o(ovf0), .drop_cnt_o(drp0), .state_o(st0));

  commit_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP_MODE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .update_i(update), .pc_i(pc), .instr_i(instr),
    .reg_addr_i(reg_addr), .reg_data_i(reg_data), .filter_en_i(filter_en),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .clear_i(clear),
    .valid_o(v1), .ready_i(ready), .out_pc_o(opc1), .out_instr_o(oin1),
    .out_reg_addr_o(ora1), .out_reg_data_o(od1), .count_o(cnt1),
    .overflow_o(ovf1), .drop_cnt_o(drp1), .state_o(st1));

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic [4:0]  ra;
    logic        filt, trig, clr, rdy;
    logic        e_valid;
    int          e_count, e_state;
    logic        e_ovf;
    int          e_drop;
    logic        chk_head;
    logic [31:0] e_pc;
    logic [4:0]  e_ra;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t v(input logic upd, input logic [31:0] p, input logic [4:0] ra,
                             input logic filt, input logic trig, input logic clr, input logic rdy,
                             input logic ev, input int ec, input int es, input logic eo,
                             input int ed, input logic ch, input logic [31:0] epc,
                             input logic [4:0] era);
    vec_t r;
    r.upd = upd; r.pc = p; r.ra = ra; r.filt = filt; r.trig = trig; r.clr = clr; r.rdy = rdy;
    r.e_valid = ev; r.e_count = ec; r.e_state = es; r.e_ovf = eo; r.e_drop = ed;
    r.chk_head = ch; r.e_pc = epc; r.e_ra = era;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic upd, input logic [31:0] p, input logic [4:0] ra,
                       input logic filt, input logic trig, input logic clr, input logic rdy);
    @(negedge clk);
    update = upd; pc = p; instr = p ^ INSTR_X; reg_addr = ra; reg_data = p + DATA_O;
    filter_en = filt; trig_en = trig; clear = clr; ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic upd, input logic [31:0] p, input logic clr, input logic rdy);
    drive(upd, p, 5'd1, 1'b0, 1'b0, clr, rdy);
  endtask

  initial begin
    rst = 1'b1; update = 0; pc = '0; instr = '0; reg_addr = '0; reg_data = '0;
    filter_en = 0; trig_en = 0; trig_pc = TRIG_PC; clear = 0; ready = 0;

    // Trigger-less ordering
    vecs[0]  = v(1, 32'h0,   1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1, 32'h0, 1);
    vecs[1]  = v(1, 32'h4,   1, 0, 0, 0, 0,  1, 2, 1, 0, 0, 1, 32'h0, 1);
    vecs[2]  = v(1, 32'h8,   1, 0, 0, 0, 0,  1, 3, 1, 0, 0, 1, 32'h0, 1);
    vecs[3]  = v(0, 32'h0,   1, 0, 0, 0, 1,  1, 2, 1, 0, 0, 1, 32'h4, 1);
    vecs[4]  = v(0, 32'h0,   1, 0, 0, 0, 1,  1, 1, 1, 0, 0, 1, 32'h8, 1);
    vecs[5]  = v(0, 32'h0,   1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 32'h0, 0);
    vecs[6]  = v(0, 32'h0,   1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    // Trigger on 0x80000010; later non-matching pcs still captured
    vecs[7]  = v(1, 32'h8000_0008, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    vecs[8]  = v(1, 32'h8000_000C, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    vecs[9]  = v(1, 32'h8000_0010, 1, 0, 1, 0, 0,  1, 1, 1, 0, 0, 1, 32'h8000_0010, 1);
    vecs[10] = v(1, 32'h8000_0014, 1, 0, 1, 0, 0,  1, 2, 1, 0, 0, 1, 32'h8000_0010, 1);
    vecs[11] = v(0, 32'h0,   1, 0, 1, 0, 1,  1, 1, 1, 0, 0, 1, 32'h8000_0014, 1);
    vecs[12] = v(0, 32'h0,   1, 0, 1, 0, 1,  0, 0, 1, 0, 0, 0, 32'h0, 0);
    vecs[13] = v(0, 32'h0,   1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    // Register-write filter
    vecs[14] = v(1, 32'h100, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    vecs[15] = v(1, 32'h104, 5,  1, 0, 0, 0,  1, 1, 1, 0, 0, 1, 32'h104, 5);
    vecs[16] = v(1, 32'h108, 0,  1, 0, 0, 0,  1, 1, 1, 0, 0, 1, 32'h104, 5);
    vecs[17] = v(1, 32'h10C, 10, 1, 0, 0, 0,  1, 2, 1, 0, 0, 1, 32'h104, 5);
    vecs[18] = v(0, 32'h0,   1,  1, 0, 0, 1,  1, 1, 1, 0, 0, 1, 32'h10C, 10);
    vecs[19] = v(0, 32'h0,   1,  0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);
    // Stop-on-full with six commits, pop while stopped, clear with discarded commit
    vecs[20] = v(1, 32'h200, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1, 32'h200, 1);
    vecs[21] = v(1, 32'h204, 1, 0, 0, 0, 0,  1, 2, 1, 0, 0, 1, 32'h200, 1);
    vecs[22] = v(1, 32'h208, 1, 0, 0, 0, 0,  1, 3, 1, 0, 0, 1, 32'h200, 1);
    vecs[23] = v(1, 32'h20C, 1, 0, 0, 0, 0,  1, 4, 2, 0, 0, 1, 32'h200, 1);
    vecs[24] = v(1, 32'h210, 1, 0, 0, 0, 0,  1, 4, 2, 1, 1, 1, 32'h200, 1);
    vecs[25] = v(1, 32'h214, 1, 0, 0, 0, 0,  1, 4, 2, 1, 2, 1, 32'h200, 1);
    vecs[26] = v(0, 32'h0,   1, 0, 0, 0, 1,  1, 3, 2, 1, 2, 1, 32'h204, 1);
    vecs[27] = v(1, 32'h300, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_ovf",   32'(ovf0), 32'd0);
    chk("rst_drop",  32'(drp0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].upd, vecs[i].pc, vecs[i].ra, vecs[i].filt, vecs[i].trig,
            vecs[i].clr, vecs[i].rdy);
      chk($sformatf("v%0d_valid", i), 32'(v0),   32'(vecs[i].e_valid));
      chk($sformatf("v%0d_count", i), 32'(cnt0), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_state", i), 32'(st0),  32'(vecs[i].e_state));
      chk($sformatf("v%0d_ovf", i),   32'(ovf0), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_drop", i),  32'(drp0), 32'(vecs[i].e_drop));
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d_pc", i),    opc0,       vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), oin0,       vecs[i].e_pc ^ INSTR_X);
        chk($sformatf("v%0d_ra", i),    32'(ora0),  32'(vecs[i].e_ra));
        chk($sformatf("v%0d_data", i),  od0,        vecs[i].e_pc + DATA_O);
      end
    end

    // Six commits pc 1..6, no pops: u1 overwrites, u0 stops
    for (int unsigned k = 1; k <= 6; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0);
    chk("wrap_count", 32'(cnt1), 32'd4);
    chk("wrap_head",  opc1,      32'd3);
    chk("wrap_drop",  32'(drp1), 32'd2);
    chk("wrap_ovf",   32'(ovf1), 32'd1);
    chk("wrap_state", 32'(st1),  32'd1);
    chk("stop_state", 32'(st0),  32'd2);
    chk("stop_head",  opc0,      32'd1);
    chk("stop_drop",  32'(drp0), 32'd2);

    // Full buffer with simultaneous push and pop: no loss, no flag
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("clr_count", 32'(cnt1), 32'd0);
    chk("clr_ovf",   32'(ovf1), 32'd0);
    for (int unsigned k = 1; k <= 4; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0);
    chk("fill_count", 32'(cnt1), 32'd4);
    cyc(1'b1, 32'd5, 1'b0, 1'b1);
    chk("pp_count", 32'(cnt1), 32'd4);
    chk("pp_ovf",   32'(ovf1), 32'd0);
    chk("pp_drop",  32'(drp1), 32'd0);
    chk("pp_head",  opc1,      32'd2);
    cyc(1'b1, 32'd6, 1'b0, 1'b1);
    chk("pp2_head", opc1,      32'd3);
    cyc(1'b1, 32'd7, 1'b0, 1'b0);
    chk("ow_head",  opc1,      32'd4);
    chk("ow_ovf",   32'(ovf1), 32'd1);
    chk("ow_drop",  32'(drp1), 32'd1);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(v1),   32'd0);
    chk("arst_count", 32'(cnt1), 32'd0);
    chk("arst_ovf",   32'(ovf1), 32'd0);
    chk("arst_drop",  32'(drp1), 32'd0);
    chk("arst_state", 32'(st1),  32'd0);
    chk("arst_u0cnt", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    update = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(v1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32, width of pc, instr and reg data.
REQ-002 Parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 Parameter WRAP_MODE, default 0; 0 = stop-on-full, 1 = overwrite oldest.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 update_i  in  1  one commit retired this cycle.
REQ-007 pc_i / instr_i  in  XLEN each  committed pc and instruction word.
REQ-008 reg_addr_i  in  5  destination register; 0 = no register write.
REQ-009 reg_data_i  in  XLEN  destination write data.
REQ-010 filter_en_i  in  1  record only commits with reg_addr_i != 0.
REQ-011 trig_en_i  in  1  hold capture until pc_i == trig_pc_i.
REQ-012 trig_pc_i  in  XLEN  trigger pc.
REQ-013 clear_i  in  1  synchronous flush, re-arm, clear flags.
REQ-014 valid_o  out  1  oldest entry available on out_* ports.
REQ-015 ready_i  in  1  consumer accepts entry when valid_o & ready_i.
REQ-016 out_pc_o, out_instr_o, out_reg_data_o  out  XLEN each; out_reg_addr_o  out  5.
REQ-017 count_o  out  $clog2(DEPTH)+1  stored entries.
REQ-018 overflow_o  out  1  sticky, a commit was dropped or overwritten.
REQ-019 drop_cnt_o  out  16  saturating count of lost commits.
REQ-020 state_o  out  2  ARMED=0, CAPTURE=1, STOPPED=2.

Function
REQ-021 Candidate = update_i & (!filter_en_i | reg_addr_i != 0).
REQ-022 ARMED: no push; go to CAPTURE on candidate & (!trig_en_i | pc_i == trig_pc_i); triggering commit is pushed that cycle.
REQ-023 CAPTURE: every candidate pushed; entry = {pc, instr, reg_addr, reg_data}.
REQ-024 Pop = valid_o & ready_i; advances read pointer next edge; out_* show head entry combinationally from storage.
REQ-025 valid_o = (count_o != 0); no bypass: push into empty buffer visible next cycle.
REQ-026 Push & pop same cycle when not full: both occur, count_o unchanged.
REQ-027 Full & push & pop same cycle: both occur normally, no loss, no flag.
REQ-028 WRAP_MODE=1, full, push, no pop: oldest overwritten, read pointer advances, count stays DEPTH, overflow_o set, drop_cnt_o +1.
REQ-029 WRAP_MODE=0: CAPTURE goes to STOPPED on the edge count reaches DEPTH.
REQ-030 STOPPED: candidates never stored; each increments drop_cnt_o and sets overflow_o; pops still allowed; exit only via clear_i or reset.
REQ-031 drop_cnt_o saturates at 16'hFFFF.
REQ-032 Pointers $clog2(DEPTH) bits, wrap naturally at DEPTH-1 -> 0.
REQ-033 clear_i has priority over push/pop: count 0, pointers 0, flags 0, state ARMED; same-cycle commit discarded and not counted.
REQ-034 Trigger compare uses full XLEN equality; trig_en_i sampled only in ARMED.

Reset
REQ-035 rst_i asserted: immediately valid_o=0, count_o=0, overflow_o=0, drop_cnt_o=0, state_o=ARMED, pointers 0.
REQ-036 Reset mid-capture discards all entries; storage contents need not reset.

Verification
REQ-037 trig_en_i=0, 3 commits pc 0x0,0x4,0x8 -> state CAPTURE, count 3, pops return pcs in order, valid_o falls after third.
REQ-038 trig_en_i=1, trig_pc_i=0x80000010, commits 0x..08,0x..0C,0x..10,0x..14 -> only 0x..10, 0x..14 stored.
REQ-039 filter_en_i=1, commits with reg_addr 0,5,0,10 -> 2 entries, reg_addr 5 then 10.
REQ-040 WRAP_MODE=0, DEPTH=4, 6 commits, no pops -> STOPPED, count 4, drop_cnt_o=2, overflow_o=1; clear_i -> ARMED, all zero.
REQ-041 WRAP_MODE=1, DEPTH=4, commits pc 1..6, no pops -> count 4, head pc 3, drop_cnt_o=2.
REQ-042 Full, push & pop same cycle -> count 4 held, overflow_o=0; rst_i mid-stream -> outputs zero asynchronously.
